// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - borrow_in LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             ready,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSub,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bo_q, bo_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic bit_diff;
  logic bit_borrow;

  // Full-subtractor slice on the current LSBs of the operand shift registers.
  always_comb begin
    bit_diff   = a_q[0] ^ b_q[0] ^ br_q;
    bit_borrow = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    br_d    = br_q;
    bo_d    = bo_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSub;
          a_d     = a;
          b_d     = b;
          br_d    = borrow_in;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      StSub: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {bit_diff, res_q[WIDTH-1:1]};
        br_d  = bit_borrow;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          diff_d  = {bit_diff, res_q[WIDTH-1:1]};
          bo_d    = bit_borrow;
`ifdef SERIAL_SUB_OVF_EN
          // Signed overflow: borrow into the MSB differs from borrow out of it.
          ovf_d   = br_q ^ bit_borrow;
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    ready      = (state_q == StIdle);
    busy       = (state_q == StSub);
    valid      = (state_q == StDone);
    diff       = diff_q;
    borrow_out = bo_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf        = ovf_q;
`endif
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4): stimulus pushes expected results,
// a negedge monitor pops and compares on every valid pulse.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         borrow_in;
  logic         ready;
  logic         busy;
  logic         valid;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .borrow_in (borrow_in),
    .ready     (ready),
    .busy      (busy),
    .valid     (valid),
    .diff      (diff),
    .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   valid_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every result the DUT presents against the scoreboard.
  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got diff=%h borrow_out=%b, required no valid pulse",
                 diff, borrow_out);
      end else begin
        exp_t e;
        logic ok;
        e  = exp_q.pop_front();
        ok = (diff === e.d) && (borrow_out === e.bo);
`ifdef SERIAL_SUB_OVF_EN
        ok = ok && (ovf === e.ov);
        if (!ok) begin
          errors++;
          $display("FAIL result: got diff=%h bo=%b ovf=%b, required diff=%h bo=%b ovf=%b",
                   diff, borrow_out, ovf, e.d, e.bo, e.ov);
        end
`else
        if (!ok) begin
          errors++;
          $display("FAIL result: got diff=%h bo=%b, required diff=%h bo=%b",
                   diff, borrow_out, e.d, e.bo);
        end
`endif
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (ready !== 1'b1) check("ready_timeout", 32'(ready), 32'd1);
  endtask

  // Issue one operation; returns #1 after the accepting edge with inputs scrambled.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                       input logic [W-1:0] ed, input logic ebo, input logic eov,
                       input bit push);
    exp_t e;
    wait_ready();
    a         = ta;
    b         = tb_v;
    borrow_in = tbin;
    start     = 1'b1;
    e.d = ed;
    e.bo = ebo;
    e.ov = eov;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    start     = 1'b0;
    a         = W'($urandom);
    b         = W'($urandom);
    borrow_in = 1'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int vc0;
    int seen;
    rst       = 1'b1;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    borrow_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_diff", 32'(diff), 32'd0);
    check("reset_borrow_out", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;

    // 9-3: result 6 and latency check.
    issue(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1, 1'b1);
    seen = 0;
    for (int k = 1; k < int'(W); k++) begin
      @(posedge clk);
      #1;
      if (valid) seen++;
    end
    check("valid_early", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    check("valid_latency", 32'(valid), 32'd1);
    @(posedge clk);
    #1;
    check("ready_after_done", 32'(ready), 32'd1);
    check("valid_one_cycle", 32'(valid), 32'd0);

    issue(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b1, 1'b1);
    issue(4'd7, 4'd7, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1);
    issue(4'hA, 4'd5, 1'b1, 4'd4, 1'b0, 1'b1, 1'b1);

    // Back-to-back with start held high: 0-0-1 then F-F.
    wait_ready();
    a         = 4'd0;
    b         = 4'd0;
    borrow_in = 1'b1;
    start     = 1'b1;
    exp_q.push_back('{d: 4'hF, bo: 1'b1, ov: 1'b0});
    @(posedge clk);
    #1;
    a         = 4'hF;
    b         = 4'hF;
    borrow_in = 1'b0;
    exp_q.push_back('{d: 4'h0, bo: 1'b0, ov: 1'b0});
    repeat (W) @(posedge clk);
    #1;
    check("b2b_valid", 32'(valid), 32'd1);
    @(posedge clk);
    #1;
    check("b2b_ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    check("b2b_accept", 32'(busy), 32'd1);
    start = 1'b0;

`ifdef SERIAL_SUB_OVF_EN
    issue(4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1, 1'b1);
    issue(4'd5, 4'd2, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1);
`endif

    // start pulsed during SUB must be ignored.
    wait_ready();
    vc0 = valid_cnt;
    issue(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1, 1'b1);
    a     = 4'd1;
    b     = 4'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_ready();
    repeat (4) @(posedge clk);
    #1;
    check("single_valid_pulse", 32'(valid_cnt - vc0), 32'd1);

    // Reset in the 2nd SUB cycle discards the operation.
    vc0 = valid_cnt;
    issue(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_ready", 32'(ready), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_diff", 32'(diff), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("rst_mid_no_valid", 32'(valid_cnt - vc0), 32'd0);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
